// File: rtl/mac8_pkg.sv
// rtl/mac8_pkg.sv - shared types and helpers for the MAC8 reversible datapath
//
// Purpose: sequencer state encoding and the counter-width helper used by the
// digit-serial reversible adder.
// Ports: none (package).
package mac8_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of bits needed to hold values 0..v-1, never less than 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/reversible_digit_slice.sv
// rtl/reversible_digit_slice.sv - DIGIT-wide ripple chain of reversible full adders
//
// Purpose: adds one digit of each operand plus a carry in a single cycle.
// Ports:
//   a_dig, b_dig : DIGIT-bit operand digits
//   c_in         : carry into bit 0 of the digit
//   s_dig        : DIGIT-bit sum digit
//   c_out        : carry out of the top cell
//   c_msb_in     : carry into the top cell (for signed overflow)
module reversible_digit_slice #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a_dig,
   input  logic [DIGIT-1:0] b_dig,
   input  logic             c_in,
   output logic [DIGIT-1:0] s_dig,
   output logic             c_out,
   output logic             c_msb_in
);

   logic [DIGIT:0]   chain;
   logic [DIGIT-1:0] unused_g1;
   logic [DIGIT-1:0] unused_g2;

   assign chain[0] = c_in;

   for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      reversible_full_adder u_rfa (
         .a    (a_dig[i]),
         .b    (b_dig[i]),
         .cin  (chain[i]),
         .anc  (1'b0),
         .sum  (s_dig[i]),
         .cout (chain[i+1]),
         .g1   (unused_g1[i]),
         .g2   (unused_g2[i])
      );
   end

   assign c_out    = chain[DIGIT];
   assign c_msb_in = chain[DIGIT-1];

endmodule

// File: rtl/reversible_full_adder.sv
// rtl/reversible_full_adder.sv - reversible full adder built from two Peres gates
//
// Purpose: one-bit full adder made of reversible gates. The ancilla enters
// the first Peres gate; the two garbage lines preserve reversibility.
// Ports:
//   a, b, cin  : addend bits and carry in
//   anc        : ancilla input, tie to 0 for full-adder behaviour
//   sum, cout  : sum bit and carry out
//   g1, g2     : garbage outputs (a and a^b)
module reversible_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic anc,
   output logic sum,
   output logic cout,
   output logic g1,
   output logic g2
);

   logic p_xor;
   logic p_and;

   // Peres(a, b, anc) -> (a, a^b, ab^anc)
   assign g1    = a;
   assign p_xor = a ^ b;
   assign p_and = (a & b) ^ anc;

   // Peres(a^b, cin, ab) -> (a^b, a^b^cin, (a^b)cin ^ ab)
   assign g2    = p_xor;
   assign sum   = p_xor ^ cin;
   assign cout  = (p_xor & cin) ^ p_and;

endmodule

// File: rtl/reversible_digit_serial_adder.sv
// rtl/reversible_digit_serial_adder.sv - digit-serial reversible adder with accumulator
//
// Purpose: adds two WIDTH-bit operands DIGIT bits per clock through a narrow
// reversible slice, with valid/ready handshakes and an accumulate mode.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid, in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b, cin            : operands and carry-in (a ignored when acc_mode=1)
//   acc_mode             : 1 selects the accumulator as operand A
//   clear                : zeroes the accumulator while idle
//   out_valid, out_ready : result handshake
//   sum, cout, overflow  : result, unsigned carry, signed overflow
module reversible_digit_serial_adder
   import mac8_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             acc_mode,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = clog2(NDIG + 1);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             acc_mode_r;

   logic [DIGIT-1:0] s_dig;
   logic             c_out;
   logic             c_msb_in;
   logic [WIDTH-1:0] next_sum;
   logic [WIDTH-1:0] op_a;

   reversible_digit_slice #(.DIGIT(DIGIT)) u_slice (
      .a_dig    (a_sh[DIGIT-1:0]),
      .b_dig    (b_sh[DIGIT-1:0]),
      .c_in     (carry),
      .s_dig    (s_dig),
      .c_out    (c_out),
      .c_msb_in (c_msb_in)
   );

   // New digit enters from the MSB side; written as a shift so that
   // DIGIT == WIDTH needs no empty part-select.
   assign next_sum = WIDTH'({s_dig, sum} >> DIGIT);

   // A clear coinciding with an accumulate accept makes operand A zero.
   assign op_a = acc_mode ? (clear ? '0 : acc) : a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         sum        <= '0;
         cout       <= 1'b0;
         overflow   <= 1'b0;
         acc        <= '0;
         cnt        <= '0;
         carry      <= 1'b0;
         a_sh       <= '0;
         b_sh       <= '0;
         acc_mode_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clear) acc <= '0;
               if (in_valid && in_ready) begin
                  a_sh       <= op_a;
                  b_sh       <= b;
                  carry      <= cin;
                  cnt        <= '0;
                  acc_mode_r <= acc_mode;
                  in_ready   <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               sum   <= next_sum;
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               carry <= c_out;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cout      <= c_out;
                  overflow  <= c_msb_in ^ c_out;
                  if (acc_mode_r) acc <= next_sum;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reversible_digit_serial_adder.sv
// tb/tb_reversible_digit_serial_adder.sv - directed self-checking bench for the digit-serial adder
module tb_reversible_digit_serial_adder;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       acc_mode;
   logic       clear;
   logic       out_ready;

   // Instance 0: DIGIT=2, 1: DIGIT=1, 2: DIGIT=4, 3: DIGIT=8
   logic       iv [4];
   logic       ir [4];
   logic       ov [4];
   logic [7:0] sm [4];
   logic       co [4];
   logic       of [4];

   int total;
   int bad;

   for (genvar k = 0; k < 4; k++) begin : g_dut
      localparam int DG = (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 4 : 8;
      reversible_digit_serial_adder #(.WIDTH(8), .DIGIT(DG)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (iv[k]),
         .in_ready  (ir[k]),
         .a         (a),
         .b         (b),
         .cin       (cin),
         .acc_mode  (acc_mode),
         .clear     (clear),
         .out_valid (ov[k]),
         .out_ready (out_ready),
         .sum       (sm[k]),
         .cout      (co[k]),
         .overflow  (of[k])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic am, input logic cl,
                         output logic [7:0] s, output logic c, output logic o,
                         output int lat);
      int g;
      g = 0;
      while (!ir[k] && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      total++;
      if (!ir[k]) begin
         bad++;
         $display("FAIL accept_wait inst=%0d in_ready=%0b required 1", k, ir[k]);
      end
      a = av; b = bv; cin = cv; acc_mode = am; clear = cl; iv[k] = 1'b1;
      @(posedge clk); #1;
      iv[k] = 1'b0; clear = 1'b0;
      lat = 0;
      while (!ov[k] && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      s = sm[k]; c = co[k]; o = of[k];
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      total++;
      if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || sm[0] !== 8'h00 || co[0] !== 1'b0 || of[0] !== 1'b0) begin
         bad++;
         $display("FAIL reset_state ir=%0b ov=%0b sum=%h cout=%0b ovf=%0b required 1 0 00 0 0",
                  ir[0], ov[0], sm[0], co[0], of[0]);
      end
   endtask

   task automatic test_add();
      logic [7:0] s; logic c; logic o; int lat;
      logic [7:0] ta [3] = '{8'h35, 8'hFF, 8'h7F};
      logic [7:0] tb [3] = '{8'h4A, 8'h01, 8'h00};
      logic       tc [3] = '{1'b0, 1'b0, 1'b1};
      logic [7:0] es [3] = '{8'h7F, 8'h00, 8'h80};
      logic       ec [3] = '{1'b0, 1'b1, 1'b0};
      logic       eo [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         run_op(0, ta[i], tb[i], tc[i], 1'b0, 1'b0, s, c, o, lat);
         total++;
         if (s !== es[i] || c !== ec[i] || o !== eo[i]) begin
            bad++;
            $display("FAIL add_%0d got sum=%h cout=%0b ovf=%0b required sum=%h cout=%0b ovf=%0b",
                     i, s, c, o, es[i], ec[i], eo[i]);
         end
         total++;
         if (lat !== 4) begin
            bad++;
            $display("FAIL latency_%0d got %0d required 4", i, lat);
         end
      end
      total++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
         bad++;
         $display("FAIL handshake_return ov=%0b ir=%0b required 0 1", ov[0], ir[0]);
      end
   endtask

   task automatic test_accumulate();
      logic [7:0] s; logic c; logic o; int lat;
      logic [7:0] bv [4] = '{8'h10, 8'h20, 8'h05, 8'h07};
      logic [7:0] es [4] = '{8'h10, 8'h30, 8'h35, 8'h07};
      // clear pulse in IDLE without an accept
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         run_op(0, 8'hAA, bv[i], 1'b0, 1'b1, (i == 3), s, c, o, lat);
         total++;
         if (s !== es[i] || c !== 1'b0) begin
            bad++;
            $display("FAIL accum_%0d got sum=%h cout=%0b required sum=%h cout=0", i, s, c, es[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int g;
      int bad_hold;
      out_ready = 1'b0;
      a = 8'h12; b = 8'h34; cin = 1'b0; acc_mode = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
      g = 0;
      while (!ov[0] && g < 50) begin
         @(posedge clk); #1;
         g++;
      end
      bad_hold = 0;
      for (int i = 0; i < 5; i++) begin
         a = 8'h55 + 8'(i); b = 8'h11;
         @(posedge clk); #1;
         if (sm[0] !== 8'h46 || ir[0] !== 1'b0 || ov[0] !== 1'b1) bad_hold++;
      end
      total++;
      if (bad_hold != 0) begin
         bad++;
         $display("FAIL backpressure_hold sum=%h ir=%0b ov=%0b required 46 0 1", sm[0], ir[0], ov[0]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      total++;
      if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
         bad++;
         $display("FAIL backpressure_release ir=%0b ov=%0b required 1 0", ir[0], ov[0]);
      end
      @(posedge clk); #1;
      total++;
      if (ir[0] !== 1'b1) begin
         bad++;
         $display("FAIL no_extra_accept ir=%0b required 1", ir[0]);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] s; logic c; logic o; int lat;
      a = 8'hF0; b = 8'h0F; cin = 1'b0; acc_mode = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || sm[0] !== 8'h00) begin
         bad++;
         $display("FAIL reset_mid_run ov=%0b ir=%0b sum=%h required 0 1 00", ov[0], ir[0], sm[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, s, c, o, lat);
      total++;
      if (s !== 8'h03) begin
         bad++;
         $display("FAIL after_reset_op got %h required 03", s);
      end
      // accumulator held 0x07 before the reset; it must now start from 0
      run_op(0, 8'hAA, 8'h05, 1'b0, 1'b1, 1'b0, s, c, o, lat);
      total++;
      if (s !== 8'h05) begin
         bad++;
         $display("FAIL acc_after_reset got %h required 05", s);
      end
   endtask

   task automatic test_back_to_back();
      int first, second, g;
      logic prev;
      first = -1; second = -1; prev = 1'b0;
      a = 8'h01; b = 8'h01; cin = 1'b0; acc_mode = 1'b0; iv[0] = 1'b1;
      for (int e = 0; e < 14; e++) begin
         @(posedge clk); #1;
         if (ov[0] && !prev) begin
            if (first < 0) first = e; else if (second < 0) second = e;
         end
         prev = ov[0];
      end
      iv[0] = 1'b0;
      g = 0;
      while (!ir[0] && g < 50) begin
         @(posedge clk); #1;
         g++;
      end
      total++;
      if (second - first != 6) begin
         bad++;
         $display("FAIL throughput got %0d cycles required 6", second - first);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] s; logic c; logic o; int lat;
      int exp_lat [4] = '{4, 8, 2, 1};
      logic [7:0] ta [3] = '{8'hC3, 8'h80, 8'h64};
      logic [7:0] tb [3] = '{8'h5A, 8'h80, 8'h32};
      logic       tc [3] = '{1'b1, 1'b0, 1'b0};
      logic [7:0] es [3] = '{8'h1E, 8'h00, 8'h96};
      logic       ec [3] = '{1'b1, 1'b1, 1'b0};
      logic       eo [3] = '{1'b0, 1'b1, 1'b1};
      for (int k = 1; k < 4; k++) begin
         for (int i = 0; i < 3; i++) begin
            run_op(k, ta[i], tb[i], tc[i], 1'b0, 1'b0, s, c, o, lat);
            total++;
            if (s !== es[i] || c !== ec[i] || o !== eo[i]) begin
               bad++;
               $display("FAIL sweep_inst%0d_vec%0d got sum=%h cout=%0b ovf=%0b required sum=%h cout=%0b ovf=%0b",
                        k, i, s, c, o, es[i], ec[i], eo[i]);
            end
            total++;
            if (lat !== exp_lat[k]) begin
               bad++;
               $display("FAIL sweep_latency_inst%0d got %0d required %0d", k, lat, exp_lat[k]);
            end
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; acc_mode = 1'b0; clear = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) iv[k] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_add();
      test_accumulate();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reversible_digit_serial_adder.md
Name: reversible_digit_serial_adder

Overview:
Parametrised, sequential successor to the combinational 4-bit reversible ripple adder used by the MAC8 datapath. It adds two WIDTH-bit operands DIGIT bits per clock through a DIGIT-wide chain of reversible full adders, carrying the ripple between cycles in a register. It has valid/ready handshakes on input and output. An accumulate mode folds each result into an internal register, so the MAC accumulation stage can share one narrow reversible adder.

Parameters:
WIDTH, 8, operand/result width; must be a multiple of DIGIT.
DIGIT, 2, bits processed per cycle; 1 <= DIGIT <= WIDTH.
NDIG (localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand handshake valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A (ignored when acc_mode=1)
b  input  WIDTH  operand B
cin  input  1  carry-in for the LSB digit
acc_mode  input  1  1: operand A := accumulator register
clear  input  1  zero the accumulator (effective only in IDLE)
out_valid  output  1  result handshake valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of bit WIDTH-1
overflow  output  1  signed overflow = carry into MSB XOR cout

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; overflow=0; accumulator=0; digit counter=0; carry register=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch b, cin and operand A into shift registers, clear the digit counter, and go to RUN. Operand A is a, or the accumulator when acc_mode=1. Latch acc_mode as well.
  - RUN: in_ready=0, out_valid=0. Each edge adds the low DIGIT bits of A and B plus the carry register through DIGIT reversible_full_adder cells, all ancilla inputs tied to 0 and garbage outputs discarded. The DIGIT-bit result shifts into sum from the MSB side, the operand registers shift right by DIGIT, and the carry register takes the chain carry-out. The counter increments. After edge number NDIG, go to DONE.
  - Last-digit edge: capture cout from the chain carry-out and overflow from the carry into the MSB cell. If the latched acc_mode=1, write the final sum into the accumulator.
  - DONE: out_valid=1; sum, cout and overflow are stable. On out_valid&out_ready, go to IDLE. out_valid drops the next cycle. No new operand is accepted in that same cycle.
- Latency: out_valid rises exactly NDIG cycles after the accept edge. Throughput is one operation per NDIG+2 cycles with out_ready held high.
- clear:
  - clear=1 in IDLE zeroes the accumulator on that edge.
  - If clear and an accept coincide with acc_mode=1, operand A = 0 (clear wins first).
  - clear is ignored in RUN and DONE.
- Backpressure: in DONE with out_ready=0, hold indefinitely. Outputs do not change and in_valid is ignored.
- Input changes during RUN or DONE have no effect; operands are latched at accept.
- Width rules: the sum is modulo 2^WIDTH. cout is the unsigned carry. overflow treats the operands as two's complement.
- Reset asserted mid-RUN or DONE aborts the operation. Partial results are lost and the accumulator returns to 0.
- DIGIT=WIDTH degenerates to a one-cycle RUN. It must still go through DONE and the handshake.

Decomposition:
- Shared package mac8_pkg: state enum (IDLE, RUN, DONE) and the counter-width function clog2(NDIG+1).
- One sub-module: reversible_digit_slice, parametrised by DIGIT. It wraps DIGIT instances of the existing reversible_full_adder.
  - Inputs: a_dig, b_dig, c_in.
  - Outputs: s_dig, c_out, c_msb_in.
  - The FSM, shift registers and accumulator stay in the top module.

Test Plan:
All scenarios use WIDTH=8, DIGIT=2, so NDIG=4.
1. a=0x35, b=0x4A, cin=0, acc_mode=0 -> sum=0x7F, cout=0, overflow=0; out_valid first high 4 cycles after the accept edge.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, overflow=1.
3. Accumulate: clear pulse in IDLE, then acc_mode=1 with b=0x10, 0x20, 0x05 (a driven 0xAA, ignored) -> successive sums 0x10, 0x30, 0x35. A further clear plus accept with b=0x07 -> sum 0x07.
4. Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> sum stable, in_ready=0, no operand accepted. After out_ready=1, in_ready returns high the next cycle.
5. Reset mid-RUN: rst_n low during RUN digit 2 -> immediately out_valid=0, in_ready=1, sum=0. A following op a=0x01, b=0x02 -> sum 0x03.
6. Parameter sweep DIGIT=1, 4, 8: random operands compared to the a+b+cin reference; latency equals 8, 2 and 1 cycles respectively.
